// File: rtl/sata_oob_generator_pkg.sv
// Shared OOB command/state types and the UI-to-clock-cycle rounding helper
// used by the SATA/SAS OOB sequence generator.
package sata_oob_pkg;

    typedef enum logic [1:0] {
        OOB_INIT = 2'd0,
        OOB_WAKE = 2'd1,
        OOB_SAS  = 2'd2,
        OOB_RSVD = 2'd3
    } oob_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } oob_state_t;

    // OOB UI rate in kHz (1.5 GHz)
    localparam int REFFREQ    = 1_500_000;
    localparam int BURST_UI   = 160;
    localparam int GAPINIT_UI = 480;
    localparam int GAPWAKE_UI = 160;
    localparam int GAPSAS_UI  = 1440;

    // Round-to-nearest conversion of an OOB UI count into clk cycles.
    function automatic int oob_cycles(input int ui, input int clkfreq);
        longint prod;
        prod = longint'(ui) * longint'(clkfreq) + longint'(REFFREQ / 2);
        return int'(prod / longint'(REFFREQ));
    endfunction

endpackage

// File: rtl/sata_oob_generator_if.sv
// Command/status bundle between the link-layer OOB FSM (master) and the
// generator (slave). Optional cfg_* fields exist with SATA_OOB_GEN_PROG_TIMING_EN.
interface sata_oob_generator_if;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       cmd_ready;
    logic       abort;
    logic       oobfinish;
    logic       busy;
    logic       done;
    logic       txelecidle;
`ifdef SATA_OOB_GEN_PROG_TIMING_EN
    logic [7:0] cfg_burst;
    logic [7:0] cfg_gap;

    modport master (
        output cmd_valid, cmd_type, abort, oobfinish, cfg_burst, cfg_gap,
        input  cmd_ready, busy, done, txelecidle
    );
    modport slave (
        input  cmd_valid, cmd_type, abort, oobfinish, cfg_burst, cfg_gap,
        output cmd_ready, busy, done, txelecidle
    );
`else
    modport master (
        output cmd_valid, cmd_type, abort, oobfinish,
        input  cmd_ready, busy, done, txelecidle
    );
    modport slave (
        input  cmd_valid, cmd_type, abort, oobfinish,
        output cmd_ready, busy, done, txelecidle
    );
`endif
endinterface

// File: rtl/sata_oob_generator_timer.sv
// Loadable down-counter with terminal-count flag; one instance times both
// bursts and gaps by being reloaded with (length - 1) at each phase start.
module sata_oob_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/sata_oob_generator.sv
// SATA/SAS OOB burst/gap sequencer driving the GT electrical-idle control.
// Define SATA_OOB_GEN_PROG_TIMING_EN to allow per-command burst/gap overrides.
module sata_oob_generator
    import sata_oob_pkg::*;
#(
    parameter int CLKFREQ   = 150_000,
    parameter int AMOUNT    = 6,
    parameter int BURSTUI   = BURST_UI,
    parameter int GAPINITUI = GAPINIT_UI,
    parameter int GAPWAKEUI = GAPWAKE_UI,
    parameter int GAPSASUI  = GAPSAS_UI
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sata_oob_generator_if.slave  bus
);

    localparam int BURST_CYC   = oob_cycles(BURSTUI, CLKFREQ);
    localparam int GAPINIT_CYC = oob_cycles(GAPINITUI, CLKFREQ);
    localparam int GAPWAKE_CYC = oob_cycles(GAPWAKEUI, CLKFREQ);
    localparam int GAPSAS_CYC  = oob_cycles(GAPSASUI, CLKFREQ);

    localparam int MAX_AB  = (BURST_CYC > GAPINIT_CYC) ? BURST_CYC : GAPINIT_CYC;
    localparam int MAX_CD  = (GAPWAKE_CYC > GAPSAS_CYC) ? GAPWAKE_CYC : GAPSAS_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int DW      = $clog2(MAX_CYC);
`ifdef SATA_OOB_GEN_PROG_TIMING_EN
    localparam int CW      = (DW > 8) ? DW : 8;
`else
    localparam int CW      = DW;
`endif
    localparam int BW      = $clog2(AMOUNT);

    localparam logic [CW-1:0] BURST_M1   = CW'(BURST_CYC - 1);
    localparam logic [CW-1:0] GAPINIT_M1 = CW'(GAPINIT_CYC - 1);
    localparam logic [CW-1:0] GAPWAKE_M1 = CW'(GAPWAKE_CYC - 1);
    localparam logic [CW-1:0] GAPSAS_M1  = CW'(GAPSAS_CYC - 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(AMOUNT - 1);

    if (BURST_CYC < 2 || GAPINIT_CYC < 2 || GAPWAKE_CYC < 2 || GAPSAS_CYC < 2) begin : g_bad_timing
        $error("sata_oob_generator: derived burst/gap cycle count below 2");
    end
    if (AMOUNT < 2 || AMOUNT > 15) begin : g_bad_amount
        $error("sata_oob_generator: AMOUNT outside 2..15");
    end

    function automatic logic [CW-1:0] gap_m1_for(input oob_cmd_t t);
        case (t)
            OOB_WAKE: return GAPWAKE_M1;
            OOB_SAS:  return GAPSAS_M1;
            default:  return GAPINIT_M1;
        endcase
    endfunction

`ifdef SATA_OOB_GEN_PROG_TIMING_EN
    // Zero keeps the parameter-derived length; 1 is clamped up to 2 cycles.
    function automatic logic [CW-1:0] eff_len_m1(input logic [7:0] cfg, input logic [CW-1:0] dflt_m1);
        if (cfg == 8'd0)     return dflt_m1;
        else if (cfg < 8'd2) return CW'(1);
        else                 return CW'(cfg) - CW'(1);
    endfunction
`endif

    oob_state_t      state_q, state_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    oob_cmd_t        cmd_in, type_q;
    logic            accept;
    logic            tmr_load, tmr_clear, tmr_tc;
    logic [CW-1:0]   tmr_val;
    logic [CW-1:0]   burst_m1_in, burst_m1_q, gap_m1;
    logic            txelecidle_q;

    assign cmd_in = oob_cmd_t'(bus.cmd_type);
    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

`ifdef SATA_OOB_GEN_PROG_TIMING_EN
    logic [7:0] cfg_gap_q;

    assign burst_m1_in = eff_len_m1(bus.cfg_burst, BURST_M1);
    assign gap_m1      = eff_len_m1(cfg_gap_q, gap_m1_for(type_q));

    always_ff @(posedge clk) begin
        if (accept) begin
            burst_m1_q <= burst_m1_in;
            cfg_gap_q  <= bus.cfg_gap;
        end
    end
`else
    assign burst_m1_in = BURST_M1;
    assign burst_m1_q  = BURST_M1;
    assign gap_m1      = gap_m1_for(type_q);
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            type_q <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        tmr_val     = burst_m1_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && cmd_in != OOB_RSVD) begin
                    state_d  = ST_BURST;
                    tmr_load = 1'b1;
                    tmr_val  = burst_m1_in;
                end
            end
            ST_BURST: begin
                if (tmr_tc) begin
                    if (burst_cnt_q == LAST_BURST) begin
                        state_d = ST_DONE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        state_d     = ST_GAP;
                        tmr_load    = 1'b1;
                        tmr_val     = gap_m1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    state_d  = ST_BURST;
                    tmr_load = 1'b1;
                    tmr_val  = burst_m1_q;
                end
            end
            ST_DONE: begin
                burst_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every busy-state transition, including DONE.
        if (bus.abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
            tmr_load    = 1'b0;
            tmr_clear   = 1'b1;
        end
    end

    sata_oob_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Masking the burst term with abort releases the line one cycle after an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txelecidle_q <= 1'b1;
        end else begin
            txelecidle_q <= ~(((state_q == ST_BURST) && !bus.abort) || bus.oobfinish);
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.txelecidle = txelecidle_q;

endmodule

// File: tb/tb_sata_oob_generator.sv
// Directed self-checking bench for sata_oob_generator: COMINIT/COMWAKE/COMSAS
// timing, reserved command, abort, oobfinish, async reset and optional cfg timing.
module tb_sata_oob_generator;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    sata_oob_generator_if bus();

    sata_oob_generator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    endtask

    // Caller is at a negedge. Cycle c (c>=1) is sampled at the c-th negedge after
    // the accept edge; six bursts of b cycles separated by gaps of g cycles.
    task automatic run_seq(input string tag, input logic [1:0] typ, input int b, input int g,
                           input int done_at, input int ofin_at, input int abort_at,
                           input int rst_at, input bit noise);
        int   last;
        int   done_seen;
        int   t;
        logic exp_idle;
        logic exp_busy;
        last      = (abort_at > 0) ? abort_at + 1 : ((rst_at > 0) ? rst_at : done_at + 1);
        done_seen = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = typ;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            t        = c - 2;
            exp_idle = !((c >= 2 && (t / (b + g)) < 6 && (t % (b + g)) < b) ||
                         (ofin_at > 0 && c > ofin_at));
            exp_busy = (c <= done_at) && !(abort_at > 0 && c > abort_at);
            chk({tag, "_txelecidle"}, bus.txelecidle, exp_idle);
            chk({tag, "_done"},       bus.done,       (c == done_at));
            chk({tag, "_busy"},       bus.busy,       exp_busy);
            chk({tag, "_cmd_ready"},  bus.cmd_ready,  !exp_busy);
            if (bus.done === 1'b1 && done_seen == 0) done_seen = c;
            if (c == done_at + 1) chk({tag, "_done_cycle"}, done_seen, done_at);
            if (c == ofin_at) bus.oobfinish = 1'b1;
            if (c == abort_at) bus.abort = 1'b1;
            if (noise && c == 40) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_type  = 2'd2;
            end
            if (noise && c == 45) bus.cmd_valid = 1'b0;
            if (c == rst_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk({tag, "_rst_txelecidle"}, bus.txelecidle, 1'b1);
                chk({tag, "_rst_cmd_ready"},  bus.cmd_ready,  1'b1);
                chk({tag, "_rst_busy"},       bus.busy,       1'b0);
                chk({tag, "_rst_done"},       bus.done,       1'b0);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        bus.oobfinish = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        bus.abort     = 1'b0;
        bus.oobfinish = 1'b0;
`ifdef SATA_OOB_GEN_PROG_TIMING_EN
        bus.cfg_burst = 8'd0;
        bus.cfg_gap   = 8'd0;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready",  bus.cmd_ready,  1'b1);
        chk("reset_busy",       bus.busy,       1'b0);
        chk("reset_done",       bus.done,       1'b0);
        chk("reset_txelecidle", bus.txelecidle, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        // COMINIT: 16-cycle bursts, 48-cycle gaps, done at 1+96+240
        run_seq("init", 2'd0, 16, 48, 337, 0, 0, 0, 1'b0);
        // COMWAKE with a spurious command while busy, then COMSAS back-to-back
        run_seq("wake", 2'd1, 16, 16, 177, 0, 0, 0, 1'b1);
        run_seq("sas",  2'd2, 16, 144, 817, 0, 0, 0, 1'b0);

        // Reserved command: accepted, ignored
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'd3;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("rsvd_cmd_ready",  bus.cmd_ready,  1'b1);
            chk("rsvd_busy",       bus.busy,       1'b0);
            chk("rsvd_done",       bus.done,       1'b0);
            chk("rsvd_txelecidle", bus.txelecidle, 1'b1);
        end

        // Abort in the gap after burst 3; abort still high at the next accept
        run_seq("abort",  2'd0, 16, 48, 337, 0, 160, 0, 1'b0);
        run_seq("reinit", 2'd0, 16, 48, 337, 0, 0, 0, 1'b0);

        // oobfinish during the first COMWAKE gap
        run_seq("ofin", 2'd1, 16, 16, 177, 20, 0, 0, 1'b0);

        // Async reset mid-burst, then a full sequence from clean counters
        run_seq("rst",       2'd0, 16, 48, 337, 0, 0, 10, 1'b0);
        run_seq("after_rst", 2'd1, 16, 16, 177, 0, 0, 0, 1'b0);

`ifdef SATA_OOB_GEN_PROG_TIMING_EN
        bus.cfg_burst = 8'd4;
        bus.cfg_gap   = 8'd1;
        run_seq("prog", 2'd0, 4, 2, 35, 0, 0, 0, 1'b0);
        bus.cfg_burst = 8'd0;
        bus.cfg_gap   = 8'd0;
        run_seq("prog_dflt", 2'd1, 16, 16, 177, 0, 0, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sata_oob_generator.md
Name: sata_oob_generator

Overview:
- Parametrised OOB sequence generator for the SATA/SAS PHY layer. Drives the transceiver electrical-idle control to produce COMRESET/COMINIT, COMWAKE and COMSAS burst/gap patterns.
- Burst and gap timings are derived from the clock frequency. Burst count is parametrised.
- Commands arrive over a valid/ready handshake, with done and abort support.
- Sits between the link-layer OOB control FSM and the GT wrapper.

Parameters:
- CLKFREQ, 150_000, clk frequency in kHz.
- AMOUNT, 6, bursts per sequence (2..15).
- BURSTUI, 160, burst length in OOB UI (1 UI = 1/1.5 GHz).
- GAPINITUI, 480, COMINIT/COMRESET gap length in UI.
- GAPWAKEUI, 160, COMWAKE gap length in UI.
- GAPSASUI, 1440, COMSAS gap length in UI.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_type  in  2  0=COMINIT/COMRESET, 1=COMWAKE, 2=COMSAS, 3=reserved.
- cmd_ready  out  1  generator idle, command can be accepted.
- abort  in  1  terminate current sequence.
- oobfinish  in  1  OOB phase over; force transmitter active.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes normally.
- txelecidle  out  1  transmitter electrical-idle control (registered).

Behaviour:
- Cycle counts, computed at elaboration: N = (UI*CLKFREQ + 750_000) / 1_500_000. At defaults: BURST=16, GAPINIT=48, GAPWAKE=16, GAPSAS=144.
- Each count must be ≥2; otherwise elaboration fails via $error.
- Counter widths are $clog2 of the largest value.
- Reset values: cmd_ready=1, busy=0, done=0, txelecidle=1, state=ST_IDLE, all counters 0.
- States: ST_IDLE, ST_BURST, ST_GAP, ST_DONE.
- ST_IDLE:
  - cmd_ready=1.
  - Accept occurs when cmd_valid & cmd_ready; cmd_type is latched, then go to ST_BURST.
  - cmd_type=3 is accepted but ignored: stay in ST_IDLE, no done pulse.
- ST_BURST:
  - burst_len_cnt counts 0..BURST-1.
  - At BURST-1: if burst_cnt==AMOUNT-1, go to ST_DONE; else burst_cnt++ and go to ST_GAP.
- ST_GAP:
  - gap_len_cnt counts 0..GAP(type)-1, then go to ST_BURST.
  - No gap follows the last burst.
- ST_DONE: lasts one cycle, done=1, clears burst_cnt, then ST_IDLE.
- cmd_ready=0 and busy=1 in ST_BURST, ST_GAP and ST_DONE.
- txelecidle_next = ~(state==ST_BURST | oobfinish), registered.
  - txelecidle falls 2 cycles after the accept edge.
  - Each burst holds txelecidle low for exactly BURST cycles.
  - Each gap holds it high for exactly GAP cycles.
- Latency, accept edge to done pulse: 1 + AMOUNT*BURST + (AMOUNT-1)*GAP cycles.
- abort:
  - While busy: next state ST_IDLE; all counters cleared; no done pulse; txelecidle high the following cycle unless oobfinish.
  - Abort wins over a simultaneous ST_DONE transition.
  - Abort in ST_IDLE has no effect and does not block a same-cycle accept.
- oobfinish:
  - Forces txelecidle=0 regardless of state.
  - Does not alter FSM sequencing.
- cmd_valid while busy is ignored and not queued.
- Asynchronous reset mid-sequence: txelecidle=1 immediately; no done pulse.

Optional Feature:
- Macro: SATA_OOB_GEN_PROG_TIMING_EN.
- Defined:
  - Adds input cfg_burst[7:0], cfg_gap[7:0], sampled together with cmd_type at accept.
  - A nonzero value replaces the parameter-derived burst length / gap length for that sequence; zero selects the default.
  - Values below 2 are clamped to 2.
  - Counter widths widen to max(8, derived width).
- Undefined: ports absent; lengths fixed by parameters.

Decomposition:
- Package sata_oob_pkg holds:
  - enum oob_cmd_t (OOB_INIT, OOB_WAKE, OOB_SAS, OOB_RSVD);
  - localparam REFFREQ=1_500_000;
  - UI constants 160/480/1440;
  - function oob_cycles(ui, clkfreq) for the rounding formula.
- One sub-module, sata_oob_timer: loadable down-counter with terminal-count flag, shared by burst and gap timing.

Test Plan:
- Defaults, COMINIT accepted at cycle 0:
  - txelecidle low cycles 2–17, high cycles 18–65;
  - 6 bursts total;
  - done pulse on cycle 1+6*16+5*48=337;
  - cmd_ready returns to 1 the cycle after done.
- COMWAKE then COMSAS back-to-back:
  - COMWAKE gaps of 16 cycles, done at cycle 177;
  - COMSAS gaps of 144 cycles, done 817 cycles after its accept.
- Abort asserted mid-gap of burst 3:
  - ST_IDLE next cycle; txelecidle stays 1; no done;
  - a new COMINIT is accepted the following cycle and produces 6 full bursts.
- oobfinish asserted during a COMWAKE gap: txelecidle=0 next cycle and stays 0; done still pulses at cycle 177.
- reset_n pulled low mid-burst: txelecidle=1 and cmd_ready=1 immediately; after release, counters restart from 0.
- With SATA_OOB_GEN_PROG_TIMING_EN, cfg_burst=4, cfg_gap=1: 4-cycle bursts, 2-cycle gaps (clamped), done at cycle 1+24+10=35.
